// File: rtl/fir_filter_if.sv
// ---------------------------------------------------------------------------
// fir_filter_if
//
// Purpose:
//   Groups the sample stream into and out of the FIR filter.
//   There is no handshake: a new sample is taken on every rising clock edge.
//
// Signals:
//   x  DATA_W  input sample, driven by the source
//   q  OUT_W   registered filtered output, driven by the filter
//
// Modports:
//   master  the source / consumer side (drives x, reads q)
//   slave   the filter side (reads x, drives q)
// ---------------------------------------------------------------------------
interface fir_filter_if #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 10
);

  logic [DATA_W-1:0] x;
  logic [OUT_W-1:0]  q;

  modport master (output x, input q);
  modport slave  (input x, output q);

endinterface

// File: rtl/fir_filter.sv
// ---------------------------------------------------------------------------
// fir_filter
//
// Purpose:
//   8-tap direct-form FIR low-pass filter with fixed unsigned coefficients.
//   One sample is consumed on every rising clk edge. The output is the
//   saturated weighted sum of the eight taps held before the edge, so a
//   sample captured at edge n first contributes to q after edge n+1.
//
// Ports:
//   clk  sole clock, rising edge active
//   rst  asynchronous active-high reset; clears every tap and q at once
//   bus  fir_filter_if.slave
//          bus.x  DATA_W unsigned input sample
//          bus.q  OUT_W  unsigned filtered output, registered
//
// Parameters:
//   DATA_W  input sample width
//   OUT_W   output width; sums above 2^OUT_W-1 clamp to all ones
//   COEF_W  coefficient width
//   C0..C7  tap coefficients, C0 weights the newest sample
// ---------------------------------------------------------------------------
module fir_filter #(
  parameter int          DATA_W = 4,
  parameter int          OUT_W  = 10,
  parameter int          COEF_W = 4,
  parameter int unsigned C0     = 1,
  parameter int unsigned C1     = 2,
  parameter int unsigned C2     = 3,
  parameter int unsigned C3     = 4,
  parameter int unsigned C4     = 4,
  parameter int unsigned C5     = 3,
  parameter int unsigned C6     = 2,
  parameter int unsigned C7     = 1
) (
  input  logic          clk,
  input  logic          rst,
  fir_filter_if.slave   bus
);

  localparam int TAPS   = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  // Eight products need three extra bits of headroom, so the sum never wraps.
  localparam int ACC_W  = PROD_W + 3;

  localparam logic [31:0] OUT_MAX = (32'd1 << OUT_W) - 32'd1;

  localparam logic [COEF_W-1:0] COEF [TAPS] = '{
    COEF_W'(C0), COEF_W'(C1), COEF_W'(C2), COEF_W'(C3),
    COEF_W'(C4), COEF_W'(C5), COEF_W'(C6), COEF_W'(C7)
  };

  logic [DATA_W-1:0] taps [TAPS];
  logic [PROD_W-1:0] prod [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [OUT_W-1:0]  q_next;
  logic [OUT_W-1:0]  q_reg;

  // Multiply every tap by its coefficient and accumulate. The taps used here
  // are the ones held before the edge, which gives the one-cycle latency.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = '0;
    end
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = PROD_W'(taps[k]) * PROD_W'(COEF[k]);
      acc     = acc + ACC_W'(prod[k]);
    end
  end

  // Clamp instead of wrapping when the sum exceeds the output range. The
  // compare is done at 32 bits so it stays correct for any OUT_W/ACC_W mix.
  always_comb begin
    q_next = OUT_W'(acc);
    if ({{(32-ACC_W){1'b0}}, acc} > OUT_MAX) begin
      q_next = OUT_MAX[OUT_W-1:0];
    end
  end

  // Delay line and output register. Reset discards all sample history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        taps[k] <= '0;
      end
      q_reg <= '0;
    end else begin
      taps[0] <= bus.x;
      for (int k = 1; k < TAPS; k++) begin
        taps[k] <= taps[k-1];
      end
      q_reg <= q_next;
    end
  end

  assign bus.q = q_reg;

endmodule

// File: tb/tb_fir_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_filter
//
// Purpose:
//   Self-checking bench for fir_filter. Expected outputs are pushed to a
//   scoreboard queue as each sample is driven and popped when the DUT
//   presents the matching output after the next edge. A second instance with
//   all coefficients at 15 exercises the output clamp.
// ---------------------------------------------------------------------------
module tb_fir_filter;

  logic clk;
  logic rst;

  fir_filter_if #(.DATA_W(4), .OUT_W(10)) bus ();
  fir_filter_if #(.DATA_W(4), .OUT_W(10)) bus_sat ();

  fir_filter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fir_filter #(
    .C0(15), .C1(15), .C2(15), .C3(15),
    .C4(15), .C5(15), .C6(15), .C7(15)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sb [$];
  int checks = 0;
  int errors = 0;
  int hist [8];
  localparam int COEF [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  // Drive one sample at the falling edge, queue its expected output, and
  // return at the following falling edge once the DUT has registered it.
  task automatic drive(input logic [3:0] xv, input logic [9:0] expv);
    bus.x = xv;
    sb.push_back(expv);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset both instances for one edge and clear the reference history.
  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
  endtask

  // Reference convolution over the last eight driven samples.
  function automatic logic [9:0] model_out();
    int sum;
    sum = 0;
    for (int k = 0; k < 8; k++) sum += COEF[k] * hist[k];
    if (sum > 1023) sum = 1023;
    return 10'(sum);
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    logic [3:0] xs [3] = '{4'd7, 4'd7, 4'd0};
    logic [9:0] es [3] = '{10'd0, 10'd7, 10'd21};
    checks++;
    if (bus.q !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: q=%0d expected 0", bus.q);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], es[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL reset_fill[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: q=%0d expected 0", bus.q);
    end
    bus.x = 4'd9;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.q !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: q=%0d expected 0", bus.q);
    end
    rst = 1'b0;
    drive(4'd0, 10'd0);
    e = sb.pop_front();
    checks++;
    if (bus.q !== e) begin
      errors++;
      $display("[TB] FAIL reset_release: q=%0d expected %0d", bus.q, e);
    end
  endtask

  task automatic test_impulse();
    logic [9:0] e;
    logic [9:0] es [10] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive((i == 0) ? 4'd1 : 4'd0, es[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL impulse[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
  endtask

  task automatic test_step();
    logic [9:0] e;
    logic [9:0] es1  [10] = '{0, 1, 3, 6, 10, 14, 17, 19, 20, 20};
    logic [9:0] es15 [10] = '{0, 15, 45, 90, 150, 210, 255, 285, 300, 300};
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'd1, es1[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL step1[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'd15, es15[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL step15[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
  endtask

  task automatic test_ramp();
    logic [9:0] e;
    logic [3:0] xs [13] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [9:0] es [13] = '{0, 1, 4, 10, 20, 29, 35, 36, 30, 20, 11, 4, 0};
    pulse_reset();
    for (int i = 0; i < 13; i++) begin
      drive(xs[i], es[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL ramp[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] e;
    logic [9:0] es [10] = '{0, 225, 450, 675, 900, 1023, 1023, 1023, 1023, 1023};
    pulse_reset();
    bus.x = 4'd0;
    for (int i = 0; i < 10; i++) begin
      bus_sat.x = 4'd15;
      sb.push_back(es[i]);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus_sat.q !== e) begin
        errors++;
        $display("[TB] FAIL saturation[%0d]: q=%0d expected %0d", i, bus_sat.q, e);
      end
    end
    bus_sat.x = 4'd0;
  endtask

  task automatic test_midstream_reset();
    logic [9:0] e;
    logic [3:0] xs [4] = '{1, 2, 3, 4};
    logic [9:0] es [4] = '{0, 1, 4, 10};
    logic [9:0] ea [5] = '{0, 1, 3, 6, 10};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], es[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL mid_pre[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 10'd0) begin
      errors++;
      $display("[TB] FAIL mid_async: q=%0d expected 0", bus.q);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd1, ea[i]);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("[TB] FAIL mid_after[%0d]: q=%0d expected %0d", i, bus.q, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    logic [3:0] xv;
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      xv = 4'($urandom_range(0, 15));
      e = model_out();
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(xv);
      drive(xv, e);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b2b_queue[%0d]: size=0 expected 1", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.q !== e) begin
          errors++;
          $display("[TB] FAIL b2b[%0d]: q=%0d expected %0d", i, bus.q, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.x = 4'd0;
    bus_sat.x = 4'd0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_step();
    test_ramp();
    test_saturation();
    test_midstream_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: time=%0t expected finish before 100000", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
